// File: rtl/side_fetch_pkg.sv
// Shared types and constants for the SIDE MIPS fetch stage.
package side_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] FETCH_BYTES = 32'd8;
  localparam logic [31:0] INST_BYTES  = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, requests instruction memory and
// drives IF/ID enable/stall/flush, absorbing misses, back-pressure and redirects.
module fetch_ctrl
  import side_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          DUAL_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic        id_stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_vector,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_PC,
  output logic        inst_en,
  output logic        inst2_en,
  output logic        ifid_stall,
  output logic        ifid_flush
);

  state_t      state;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] target;
  logic        deliver;

  assign imem_addr = pc;
  assign IF_PC     = pc;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    redirect    = exc_redirect | br_redirect;
    target      = exc_redirect ? exc_vector : br_target;
    target[1:0] = 2'b00;
    deliver     = 1'b0;
    imem_req    = 1'b0;
    inst_en     = 1'b0;
    inst2_en    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    case (state)
      FETCH, MISS: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (imem_valid && !id_stall) begin
          deliver  = 1'b1;
          inst_en  = 1'b1;
          // Slot 2 only exists when the PC points at the first word of the block.
          inst2_en = DUAL_EN & ~pc[2];
        end else begin
          ifid_stall = id_stall;
        end
      end
      DRAIN:   ifid_flush = redirect;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      pc    <= RESET_PC;
      state <= IDLE;
    end else if (state == IDLE) begin
      state <= FETCH;
    end else if (redirect) begin
      pc <= target;
      // A cancelled miss still owes us a response; wait it out before refetching.
      if (state == MISS || (state == DRAIN && !imem_valid)) state <= DRAIN;
      else                                                  state <= FETCH;
    end else begin
      if (deliver) pc <= pc + (inst2_en ? FETCH_BYTES : INST_BYTES);
      case (state)
        FETCH:   if (!imem_valid) state <= MISS;
        MISS:    if (imem_valid)  state <= FETCH;
        DRAIN:   if (imem_valid)  state <= FETCH;
        default: ;
      endcase
    end
  end

endmodule
